alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_arbiter_rr_arb2.sv | 20 ++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU function codes
// and the arbiter FSM state type.
package alu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the requester not granted last wins;
// last=1 means req1 was granted most recently.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU. One operation
// in flight at a time: accept (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);
  state_t              r_state, w_nxt;
  logic                r_last;
  logic                r_id;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_res;
  logic                r_zero;
  logic [1:0]          w_gnt;
  logic                w_accept;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (r_last),
    .en   (r_state == IDLE),
    .gnt  (w_gnt)
  );

  // Grant is only non-zero for a valid requester in IDLE, so it doubles as ready.
  assign w_accept   = |w_gnt;
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nxt = EXEC;
      EXEC:    w_nxt = RESP;
      RESP:    if (rsp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // last=1 out of reset so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt[1];
      r_id   <= w_gnt[1];
      r_op   <= w_gnt[1] ? req1_op : req0_op;
      r_a    <= w_gnt[1] ? req1_a  : req0_a;
      r_b    <= w_gnt[1] ? req1_b  : req0_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_zero <= 1'b0;
    end else if (r_state == EXEC) begin
      r_res  <= alu_result;
      r_zero <= alu_zero;
    end
  end

  assign rsp_valid   = (r_state == RESP);
  assign rsp_id      = r_id;
  assign rsp_result  = r_res;
  assign rsp_zero    = r_zero;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_control = r_op;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always_comb begin
    case (alu_control)
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_result == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single requester, full accept/exec/respond cycle with rsp_ready high.
  task automatic run_op(input bit id, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ez,
                        input string tag);
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk({tag, ".rdy0"}, req0_ready, !id);
    chk({tag, ".rdy1"}, req1_ready, id);
    step();
    req0_valid = 0; req1_valid = 0;
    chk({tag, ".ctl"}, alu_control, op);
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_b"}, alu_b, b);
    chk({tag, ".exec_vld"}, rsp_valid, 0);
    step();
    chk({tag, ".vld"}, rsp_valid, 1);
    chk({tag, ".id"}, rsp_id, id);
    chk({tag, ".res"}, rsp_result, er);
    chk({tag, ".zero"}, rsp_zero, ez);
    step();
    chk({tag, ".idle_vld"}, rsp_valid, 0);
  endtask

  logic        exp_id [3] = '{0, 1, 0};
  logic [15:0] exp_res[3] = '{16'd0, 16'd1, 16'd0};
  logic        exp_z  [3] = '{1, 0, 1};

  initial begin
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    step(); step();
    chk("rst.vld", rsp_valid, 0);
    chk("rst.res", rsp_result, 0);
    chk("rst.ctl", alu_control, 0);
    chk("rst.alu_a", alu_a, 0);
    rst_n = 1;
    step();
    chk("idle.rdy0", req0_ready, 0);
    chk("idle.rdy1", req1_ready, 0);

    run_op(0, 3'b000, 16'd5, 16'd7, 16'd12, 0, "add");

    // Both requesters valid every cycle: alternate starting with req0.
    rst_n = 0; step(); rst_n = 1; step();
    req0_valid = 1; req0_op = 3'b001; req0_a = 16'd9; req0_b = 16'd9;
    req1_valid = 1; req1_op = 3'b100; req1_a = 16'd3; req1_b = 16'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rr%0d.rdy0", i), req0_ready, !exp_id[i]);
      chk($sformatf("rr%0d.rdy1", i), req1_ready, exp_id[i]);
      step();
      if (i == 2) begin req0_valid = 0; req1_valid = 0; end
      chk($sformatf("rr%0d.exec_rdy", i), {req1_ready, req0_ready}, 0);
      step();
      chk($sformatf("rr%0d.resp_rdy", i), {req1_ready, req0_ready}, 0);
      chk($sformatf("rr%0d.id", i), rsp_id, exp_id[i]);
      chk($sformatf("rr%0d.res", i), rsp_result, exp_res[i]);
      chk($sformatf("rr%0d.zero", i), rsp_zero, exp_z[i]);
      step();
    end

    // Backpressure on an all-ones result while both requesters wait.
    req0_valid = 1; req0_op = 3'b011; req0_a = 16'hFF00; req0_b = 16'h00FF;
    #1;
    chk("bp.rdy0", req0_ready, 1);
    step();
    req0_valid = 0; rsp_ready = 0;
    step();
    req0_valid = 1; req0_op = 3'b000; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1; req1_op = 3'b000; req1_a = 16'd1; req1_b = 16'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d.vld", k), rsp_valid, 1);
      chk($sformatf("bp%0d.id", k), rsp_id, 0);
      chk($sformatf("bp%0d.res", k), rsp_result, 16'hFFFF);
      chk($sformatf("bp%0d.zero", k), rsp_zero, 0);
      chk($sformatf("bp%0d.rdy", k), {req1_ready, req0_ready}, 0);
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    step();
    chk("bp.done", rsp_valid, 0);

    run_op(0, 3'b000, 16'hFFFF, 16'd1, 16'd0, 1, "wrap");
    run_op(1, 3'b111, 16'd2, 16'd3, 16'd5, 0, "op7");

    // Reset during EXEC of a req0 op: response discarded, tie goes to req0 again.
    req0_valid = 1; req0_op = 3'b000; req0_a = 16'd4; req0_b = 16'd4;
    step();
    req0_valid = 0;
    chk("mr.exec_ctl_a", alu_a, 16'd4);
    rst_n = 0;
    #1;
    chk("mr.vld", rsp_valid, 0);
    chk("mr.id", rsp_id, 0);
    chk("mr.res", rsp_result, 0);
    chk("mr.zero", rsp_zero, 0);
    chk("mr.alu_a", alu_a, 0);
    chk("mr.alu_b", alu_b, 0);
    chk("mr.ctl", alu_control, 0);
    step(); step();
    rst_n = 1;
    step();
    chk("mr.post_vld", rsp_valid, 0);
    step();
    chk("mr.post_vld2", rsp_valid, 0);
    req0_valid = 1; req0_op = 3'b000; req0_a = 16'd10; req0_b = 16'd20;
    req1_valid = 1; req1_op = 3'b001; req1_a = 16'd1;  req1_b = 16'd1;
    #1;
    chk("mr.tie_rdy0", req0_ready, 1);
    chk("mr.tie_rdy1", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    chk("mr.rsp_vld", rsp_valid, 1);
    chk("mr.rsp_id", rsp_id, 0);
    chk("mr.rsp_res", rsp_result, 16'd30);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
